// File: rtl/image_stream_source.sv
// Test-pattern frame generator driving an AXI4-Stream video port.
// tuser marks the last pixel of each line; tlast marks the last pixel of the frame.
module image_stream_source #(
  parameter int AXIS_DATA_WIDTH        = 8,
  parameter int IMAGE_WIDTH_SIZE       = 512,
  parameter int IMAGE_WIDTH_LOG2_SIZE  = 9,
  parameter int IMAGE_HEIGHT_SIZE      = 512,
  parameter int IMAGE_HEIGHT_LOG2_SIZE = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [1:0]                 pattern_sel,
  input  logic [AXIS_DATA_WIDTH-1:0] const_value,
  input  logic [7:0]                 num_frames,
  output logic                       busy,
  output logic                       done,
  output logic                       m_axis_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast
);

  // state  | meaning
  // IDLE   | waiting for start; stream quiet
  // STREAM | presenting pixels, tvalid held high
  // FINISH | one-cycle done pulse, then IDLE
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_FINISH = 2'd2} state_t;

  localparam logic [IMAGE_WIDTH_LOG2_SIZE-1:0]  X_MAX = IMAGE_WIDTH_LOG2_SIZE'(IMAGE_WIDTH_SIZE - 1);
  localparam logic [IMAGE_HEIGHT_LOG2_SIZE-1:0] Y_MAX = IMAGE_HEIGHT_LOG2_SIZE'(IMAGE_HEIGHT_SIZE - 1);
  localparam logic [IMAGE_WIDTH_LOG2_SIZE-1:0]  X_ONE = IMAGE_WIDTH_LOG2_SIZE'(1);
  localparam logic [IMAGE_HEIGHT_LOG2_SIZE-1:0] Y_ONE = IMAGE_HEIGHT_LOG2_SIZE'(1);

  state_t state_q, state_d;

  logic [IMAGE_WIDTH_LOG2_SIZE-1:0]  x_q, x_nxt;
  logic [IMAGE_HEIGHT_LOG2_SIZE-1:0] y_q, y_nxt;
  logic [7:0]                        fc_q;
  logic [7:0]                        nf_q;
  logic [1:0]                        pat_q;
  logic [AXIS_DATA_WIDTH-1:0]        cv_q;
  logic                              stop_pend_q;
  logic [AXIS_DATA_WIDTH-1:0]        tdata_q;
  logic                              tuser_q;
  logic                              tlast_q;

  logic hs;
  logic frame_end;
  logic frames_met;
  logic end_run;

  function automatic logic [AXIS_DATA_WIDTH-1:0] pixel(
    input logic [1:0]                 sel,
    input logic [AXIS_DATA_WIDTH-1:0] cv,
    input logic [31:0]                px,
    input logic [31:0]                py
  );
    logic [AXIS_DATA_WIDTH-1:0] v;
    case (sel)
      2'd0:    v = AXIS_DATA_WIDTH'(px);
      2'd1:    v = AXIS_DATA_WIDTH'(py);
      2'd2:    v = (px[3] ^ py[3]) ? '1 : '0;
      default: v = cv;
    endcase
    return v;
  endfunction

  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (x_q == X_MAX) begin
      x_nxt = '0;
      y_nxt = (y_q == Y_MAX) ? '0 : y_q + Y_ONE;
    end else begin
      x_nxt = x_q + X_ONE;
    end
  end

  assign hs         = (state_q == S_STREAM) && m_axis_tready;
  assign frame_end  = (x_q == X_MAX) && (y_q == Y_MAX);
  assign frames_met = (nf_q != 8'd0) && ((fc_q + 8'd1) == nf_q);
  // a stop arriving on the tlast beat itself still ends the run at this frame
  assign end_run    = hs && frame_end && (frames_met || stop_pend_q || stop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (end_run) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state_q == S_STREAM);
    busy          = (state_q == S_STREAM);
    done          = (state_q == S_FINISH);
    m_axis_tdata  = tdata_q;
    m_axis_tuser  = tuser_q;
    m_axis_tlast  = tlast_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      fc_q        <= '0;
      nf_q        <= '0;
      pat_q       <= '0;
      cv_q        <= '0;
      stop_pend_q <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
    end else if (state_q == S_IDLE) begin
      stop_pend_q <= start & stop;
      if (start) begin
        pat_q   <= pattern_sel;
        cv_q    <= const_value;
        nf_q    <= num_frames;
        x_q     <= '0;
        y_q     <= '0;
        fc_q    <= '0;
        tdata_q <= pixel(pattern_sel, const_value, 32'd0, 32'd0);
        tuser_q <= (X_MAX == '0);
        tlast_q <= (X_MAX == '0) && (Y_MAX == '0);
      end
    end else if (state_q == S_STREAM) begin
      if (stop) stop_pend_q <= 1'b1;
      if (hs) begin
        x_q     <= x_nxt;
        y_q     <= y_nxt;
        tdata_q <= pixel(pat_q, cv_q, 32'(x_nxt), 32'(y_nxt));
        tuser_q <= (x_nxt == X_MAX);
        tlast_q <= (x_nxt == X_MAX) && (y_nxt == Y_MAX);
        if (frame_end) fc_q <= fc_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_stream_source.sv
// Scoreboard bench: a 4x3 instance for stream behaviour, a 16x16 instance for the checkerboard.
module tb_image_stream_source;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, stop = 1'b0, tready = 1'b1;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] const_value = 8'd0, num_frames = 8'd0;
  logic       busy, done, tvalid, tuser, tlast;
  logic [7:0] tdata;

  logic       start_b = 1'b0;
  logic       busy_b, done_b, tvalid_b, tuser_b, tlast_b;
  logic [7:0] tdata_b;

  image_stream_source #(
    .AXIS_DATA_WIDTH(8), .IMAGE_WIDTH_SIZE(W), .IMAGE_WIDTH_LOG2_SIZE(2),
    .IMAGE_HEIGHT_SIZE(H), .IMAGE_HEIGHT_LOG2_SIZE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .pattern_sel(pattern_sel), .const_value(const_value), .num_frames(num_frames),
    .busy(busy), .done(done), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tready(tready), .m_axis_tuser(tuser), .m_axis_tlast(tlast)
  );

  image_stream_source #(
    .AXIS_DATA_WIDTH(8), .IMAGE_WIDTH_SIZE(16), .IMAGE_WIDTH_LOG2_SIZE(4),
    .IMAGE_HEIGHT_SIZE(16), .IMAGE_HEIGHT_LOG2_SIZE(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(1'b0),
    .pattern_sel(2'd2), .const_value(8'h00), .num_frames(8'd1),
    .busy(busy_b), .done(done_b), .m_axis_tvalid(tvalid_b), .m_axis_tdata(tdata_b),
    .m_axis_tready(1'b1), .m_axis_tuser(tuser_b), .m_axis_tlast(tlast_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_a = 0, done_a = 0, hs_b = 0, done_cnt_b = 0;
  int h0, d0, t0;
  bit ready_random = 1'b0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [7:0] cap_b[256];
  bit         prev_stall = 1'b0;
  logic [9:0] prev_beat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_px(input int p, input logic [7:0] cv, input int x, input int y);
    case (p)
      0:       return 8'(x % 256);
      1:       return 8'(y % 256);
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return cv;
    endcase
  endfunction

  task automatic push_frames(input int which, input int p, input logic [7:0] cv,
                             input int nfr, input int w, input int h);
    logic [9:0] e;
    for (int f = 0; f < nfr; f++)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          e = {model_px(p, cv, x, y), 1'(x == w - 1), 1'(x == w - 1 && y == h - 1)};
          if (which == 0) exp_a.push_back(e);
          else            exp_b.push_back(e);
        end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    tready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) chk("stall_hold", {31'd0, tvalid} << 10 | {22'd0, tdata, tuser, tlast},
                          {21'd0, 1'b1, prev_beat});
      if (tvalid && tready) begin
        if (exp_a.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else chk("beat", {22'd0, tdata, tuser, tlast}, {22'd0, exp_a.pop_front()});
        chk("busy_in_stream", {31'd0, busy}, 32'd1);
        hs_a++;
      end
      if (done) begin
        done_a++;
        chk("done_flags", {30'd0, busy, tvalid}, 32'd0);
      end
      prev_stall = tvalid && !tready;
      prev_beat  = {tdata, tuser, tlast};
      if (tvalid_b) begin
        if (exp_b.size() == 0) chk("unexpected_beat_b", 32'd1, 32'd0);
        else chk("beat_b", {22'd0, tdata_b, tuser_b, tlast_b}, {22'd0, exp_b.pop_front()});
        if (hs_b < 256) cap_b[hs_b] = tdata_b;
        hs_b++;
      end
      if (done_b) done_cnt_b++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_run(input int p, input logic [7:0] cv, input int nf,
                           input int exp_frames, input bit with_stop);
    push_frames(0, p, cv, exp_frames, W, H);
    h0 = hs_a;
    d0 = done_a;
    @(posedge clk);
    #1;
    pattern_sel = 2'(p);
    const_value = cv;
    num_frames  = 8'(nf);
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    t0 = cyc;
    // settings must be latched: scramble the inputs once the run is accepted
    pattern_sel = 2'($urandom_range(0, 3));
    const_value = 8'($urandom);
    num_frames  = 8'($urandom_range(1, 9));
  endtask

  task automatic wait_beats(input int n);
    int k;
    for (k = 0; k < 2000 && (hs_a - h0) < n; k++) begin
      @(negedge clk);
      #1;
    end
    if ((hs_a - h0) < n) chk("wait_beats_timeout", hs_a - h0, n);
  endtask

  task automatic finish_run(input string name, input int nbeats, input bit chk_lat);
    int k;
    for (k = 0; k < 3000 && done_a == d0; k++) begin
      @(negedge clk);
      #1;
    end
    if (done_a == d0) begin
      chk({name, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      if (chk_lat) chk({name, "_latency"}, cyc - t0, nbeats);
      @(negedge clk);
      #1;
      chk({name, "_done_pulses"}, done_a - d0, 32'd1);
      chk({name, "_beats"}, hs_a - h0, nbeats);
      chk({name, "_idle"}, {30'd0, busy, tvalid}, 32'd0);
      chk({name, "_queue_empty"}, exp_a.size(), 32'd0);
    end
  endtask

  initial begin
    #12;
    chk("reset_outputs", {21'd0, busy, done, tvalid, tdata, tuser, tlast}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    start_run(0, 8'h00, 1, 1, 1'b0);
    finish_run("basic", 12, 1'b1);

    ready_random = 1'b1;
    start_run(1, 8'h00, 1, 1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pattern_sel = 2'd3;
    num_frames  = 8'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_run("backpressure", 12, 1'b0);
    ready_random = 1'b0;

    start_run(3, 8'hA5, 3, 3, 1'b0);
    finish_run("multi", 36, 1'b1);

    start_run(0, 8'h00, 0, 2, 1'b0);
    wait_beats(16);
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    finish_run("cont_stop", 24, 1'b1);

    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    start_run(1, 8'h00, 2, 2, 1'b0);
    finish_run("idle_stop_ignored", 24, 1'b1);

    start_run(0, 8'h00, 0, 1, 1'b1);
    finish_run("start_and_stop", 12, 1'b1);

    for (int i = 0; i < 4; i++) begin
      int p, nf;
      logic [7:0] cv;
      p  = $urandom_range(0, 3);
      nf = $urandom_range(1, 2);
      cv = 8'($urandom);
      ready_random = 1'b1;
      start_run(p, cv, nf, nf, 1'b0);
      finish_run("random", nf * 12, 1'b0);
    end
    ready_random = 1'b0;

    push_frames(1, 2, 8'h00, 1, 16, 16);
    @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < 600 && done_cnt_b == 0; k++) @(posedge clk);
    #1;
    chk("checker_done", done_cnt_b, 32'd1);
    chk("checker_beats", hs_b, 32'd256);
    chk("checker_0_0", {24'd0, cap_b[0]}, 32'h00);
    chk("checker_8_0", {24'd0, cap_b[8]}, 32'hFF);
    chk("checker_8_8", {24'd0, cap_b[8 * 16 + 8]}, 32'h00);
    chk("checker_0_8", {24'd0, cap_b[8 * 16]}, 32'hFF);

    start_run(2, 8'h00, 1, 1, 1'b0);
    wait_beats(5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_tvalid", {31'd0, tvalid}, 32'd0);
    exp_a.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    start_run(0, 8'h00, 1, 1, 1'b0);
    finish_run("after_reset", 12, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
